// File: rtl/uart_cmd_engine.sv
// Frame-level UART command processor: capture, decode, respond, trigger.
// Optional checksum check/generation enabled by UART_CMD_CHECKSUM_EN.
module uart_cmd_engine #(
  parameter int FRAME_BYTES = 18,
  parameter int NUM_REGS    = 8,
  parameter int TX_HOLDOFF  = 4096
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [FRAME_BYTES*8-1:0] rx_frame,
  output logic                     tx_trigger,
  output logic [FRAME_BYTES*8-1:0] tx_frame,
  output logic                     busy,
  output logic [7:0]               reg0_out,
  output logic [7:0]               drop_count
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = (TX_HOLDOFF > 1) ? $clog2(TX_HOLDOFF) : 1;

  typedef enum logic [2:0] {
    IDLE, DECODE, BUILD, SEND, HOLDOFF
  } state_t;

  typedef enum logic [2:0] {
    RSP_K, RSP_R, RSP_A, RSP_E, RSP_S, RSP_N
  } rsp_t;

  state_t          state, state_nxt;
  rsp_t            rsp;
  logic [7:0]      err;
  logic [7:0]      ok_count;
  logic [FW-1:0]   cap;
  logic [FW-1:0]   resp;
  logic [CW-1:0]   cnt;
  logic [7:0]      regs [NUM_REGS];
  logic [7:0]      op, addr, data;
  logic            addr_ok, sum_ok;

  assign op      = cap[7:0];
  assign addr    = cap[15:8];
  assign data    = cap[23:16];
  assign addr_ok = {1'b0, addr} < 9'(NUM_REGS);

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] sum_rx;
  always_comb begin
    sum_rx = '0;
    for (int k = 0; k < FRAME_BYTES - 1; k++)
      sum_rx ^= cap[8*k +: 8];
  end
  assign sum_ok = (sum_rx == cap[FW-1 -: 8]);
`else
  assign sum_ok = 1'b1;
`endif

  assign busy       = (state != IDLE);
  // A reset in the SEND cycle must swallow the pulse.
  assign tx_trigger = (state == SEND) && !reset;
  assign reg0_out   = regs[0];

  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rx_valid) state_nxt = DECODE;
      DECODE:  state_nxt = BUILD;
      BUILD:   state_nxt = SEND;
      SEND:    state_nxt = HOLDOFF;
      HOLDOFF: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    resp = '0;
    unique case (rsp)
      RSP_K: begin
        resp[7:0]   = 8'h4B;
        resp[15:8]  = addr;
        resp[23:16] = data;
      end
      RSP_R: begin
        resp[7:0]   = 8'h52;
        resp[15:8]  = addr;
        resp[23:16] = regs[addr[AW-1:0]];
      end
      RSP_A: begin
        for (int k = 0; k < FRAME_BYTES - 1; k++)
          resp[8*k +: 8] = 8'h30 + 8'((k + 1) % 10);
      end
      RSP_E: resp = cap;
      RSP_S: begin
        resp[7:0]   = 8'h53;
        resp[15:8]  = drop_count;
        resp[23:16] = ok_count;
      end
      default: begin
        resp[7:0]   = 8'h4E;
        resp[15:8]  = err;
      end
    endcase
`ifdef UART_CMD_CHECKSUM_EN
    if (rsp != RSP_E) begin
      for (int k = 0; k < FRAME_BYTES - 1; k++)
        resp[FW-1 -: 8] ^= resp[8*k +: 8];
    end
`endif
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cap        <= '0;
      rsp        <= RSP_N;
      err        <= '0;
      tx_frame   <= '0;
      cnt        <= '0;
      drop_count <= '0;
      ok_count   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      if (rx_valid && busy && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      unique case (state)
        IDLE: if (rx_valid) cap <= rx_frame;
        DECODE: begin
          err <= '0;
          if (!sum_ok) begin
            rsp <= RSP_N;
            err <= 8'h03;
          end else if (op == 8'h57 || op == 8'h52) begin
            rsp <= (op == 8'h57) ? RSP_K : RSP_R;
            if (!addr_ok) begin
              rsp <= RSP_N;
              err <= 8'h01;
            end
          end else if (op == 8'h41) rsp <= RSP_A;
          else if (op == 8'h45) rsp <= RSP_E;
          else if (op == 8'h53) rsp <= RSP_S;
          else begin
            rsp <= RSP_N;
            err <= 8'h02;
          end
        end
        BUILD: begin
          tx_frame <= resp;
          if (rsp == RSP_K) regs[addr[AW-1:0]] <= data;
          if (rsp != RSP_N) ok_count <= ok_count + 8'd1;
        end
        SEND:    cnt <= CW'(TX_HOLDOFF - 1);
        HOLDOFF: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
